// File: rtl/mux_32_1_if.sv
// Bus bundle for mux_32_1: data/select toward the mux, selected bit (comb and registered) back.
interface mux_32_1_if;
   logic [31:0] in;
   logic [4:0]  sel;
   logic        out;
   logic        out_q;

   modport master (output in, output sel, input out, input out_q);
   modport slave  (input in, input sel, output out, output out_q);
endinterface

// File: rtl/mux_32_1.sv
// 32:1 single-bit mux built as a 5-level tree of 2:1 selectors, with an optional registered copy.
// Define MUX_32_1_OUT_REG_EN to register out_q; otherwise out_q mirrors out combinationally.
module mux_32_1 (
   input  logic      clk,
   input  logic      reset,
   mux_32_1_if.slave bus
);
   logic [15:0] w_l0;
   logic [7:0]  w_l1;
   logic [3:0]  w_l2;
   logic [1:0]  w_l3;
   logic        w_l4;

   // Level n uses sel[n]; a select bit of 1 picks the odd (upper) input.
   for (genvar k = 0; k < 16; k++) begin : g_l0
      assign w_l0[k] = bus.sel[0] ? bus.in[2*k+1] : bus.in[2*k];
   end
   for (genvar k = 0; k < 8; k++) begin : g_l1
      assign w_l1[k] = bus.sel[1] ? w_l0[2*k+1] : w_l0[2*k];
   end
   for (genvar k = 0; k < 4; k++) begin : g_l2
      assign w_l2[k] = bus.sel[2] ? w_l1[2*k+1] : w_l1[2*k];
   end
   for (genvar k = 0; k < 2; k++) begin : g_l3
      assign w_l3[k] = bus.sel[3] ? w_l2[2*k+1] : w_l2[2*k];
   end
   assign w_l4    = bus.sel[4] ? w_l3[1] : w_l3[0];

   assign bus.out = w_l4;

`ifdef MUX_32_1_OUT_REG_EN
   logic r_out_q;

   always_ff @(posedge clk) begin
      if (reset) r_out_q <= 1'b0;
      else       r_out_q <= w_l4;
   end

   assign bus.out_q = r_out_q;
`else
   // Clock and reset have no function in this build.
   logic w_unused;
   assign w_unused  = clk ^ reset;
   assign bus.out_q = w_l4;
`endif
endmodule

// File: tb/tb_mux_32_1.sv
// Randomised and directed self-checking bench for mux_32_1 (both MUX_32_1_OUT_REG_EN builds).
module tb_mux_32_1;
   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;

   mux_32_1_if bus ();

   mux_32_1 u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic ref_bit(input logic [31:0] v, input logic [4:0] s);
      int unsigned sh;
      sh = int'(s);
      return ((v >> sh) & 32'd1) != 32'd0;
   endfunction

   // Reference for out_q after an edge, given the values present at that edge.
   function automatic logic ref_q(input logic [31:0] v, input logic [4:0] s, input logic rst);
`ifdef MUX_32_1_OUT_REG_EN
      return rst ? 1'b0 : ref_bit(v, s);
`else
      return ref_bit(v, s);
`endif
   endfunction

   task automatic chk(input string tag, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b (in=%h sel=%0d reset=%b t=%0t)",
                  tag, act, exp, bus.in, bus.sel, reset, $time);
      end
   endtask

   task automatic edge_wait();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic e;
      n_checks = 0;
      n_errors = 0;
      reset    = 1'b1;
      bus.in   = '0;
      bus.sel  = '0;
      edge_wait();
      edge_wait();
      chk("reset_out_q", bus.out_q, 1'b0);
      chk("reset_out", bus.out, 1'b0);
      reset = 1'b0;

      // Exhaustive select, once with reset low and once with reset high.
      for (int r = 0; r < 2; r++) begin
         reset  = (r == 1);
         bus.in = 32'hA5A5_F00F;
         for (int s = 0; s < 32; s++) begin
            bus.sel = 5'(s);
            #1;
            chk("exh_out", bus.out, ref_bit(bus.in, bus.sel));
`ifndef MUX_32_1_OUT_REG_EN
            chk("exh_q_eq_out", bus.out_q, ref_bit(bus.in, bus.sel));
`endif
            e = ref_q(bus.in, bus.sel, reset);
            edge_wait();
            chk("exh_q", bus.out_q, e);
         end
      end
      reset = 1'b0;
      bus.sel = 5'd0;
      chk("exh_spot0", bus.out, 1'b1);
      bus.sel = 5'd4;
      #1 chk("exh_spot4", bus.out, 1'b0);
      bus.sel = 5'd31;
      #1 chk("exh_spot31", bus.out, 1'b1);

      // One-hot walk: purely combinational.
      for (int k = 0; k < 32; k++) begin
         bus.in = 32'd1 << k;
         for (int s = 0; s < 32; s++) begin
            bus.sel = 5'(s);
            #1 chk("onehot", bus.out, s == k);
         end
      end
      edge_wait();

`ifdef MUX_32_1_OUT_REG_EN
      bus.in  = 32'h0000_0001;
      bus.sel = 5'd0;
      edge_wait();
      chk("lat_sel0", bus.out_q, 1'b1);
      bus.sel = 5'd1;
      edge_wait();
      chk("lat_sel1", bus.out_q, 1'b0);

      bus.in  = 32'hFFFF_FFFF;
      bus.sel = 5'($urandom_range(0, 31));
      reset   = 1'b1;
      for (int i = 0; i < 3; i++) begin
         edge_wait();
         chk("rst_hold_q", bus.out_q, 1'b0);
         chk("rst_hold_out", bus.out, 1'b1);
      end
      reset = 1'b0;
      edge_wait();
      chk("rst_release_q", bus.out_q, 1'b1);

      bus.in  = '0;
      bus.sel = 5'd17;
      edge_wait();
      bus.in[17] = 1'b1;
      #1;
      chk("comb_rise_out", bus.out, 1'b1);
      chk("comb_rise_q_held", bus.out_q, 1'b0);
      edge_wait();
      chk("comb_rise_q", bus.out_q, 1'b1);
      bus.in[17] = 1'b0;
      #1;
      chk("comb_fall_out", bus.out, 1'b0);
      chk("comb_fall_q_held", bus.out_q, 1'b1);
      edge_wait();
      chk("comb_fall_q", bus.out_q, 1'b0);
`endif

      // Random traffic with occasional reset pulses and mid-cycle input changes.
      for (int i = 0; i < 400; i++) begin
         bus.in  = $urandom;
         bus.sel = 5'($urandom_range(0, 31));
         reset   = ($urandom_range(0, 11) == 0);
         #1 chk("rnd_out", bus.out, ref_bit(bus.in, bus.sel));
         if ($urandom_range(0, 1) == 1) begin
            #2;
            bus.in  = $urandom;
            bus.sel = 5'($urandom_range(0, 31));
            #1 chk("rnd_mid_out", bus.out, ref_bit(bus.in, bus.sel));
         end
`ifndef MUX_32_1_OUT_REG_EN
         chk("rnd_q_eq_out", bus.out_q, ref_bit(bus.in, bus.sel));
`endif
         e = ref_q(bus.in, bus.sel, reset);
         edge_wait();
         chk("rnd_q", bus.out_q, e);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
